ntt_iter_core: RTL

- Parametrised iterative N-point forward NTT engine over Z_q.
- Generalises the fixed 2/4-point combinational butterfly networks to arbitrary power-of-two N and data width W.
- Uses one pipelined radix-2 DIT butterfly, reused across all log2(N) stages.
- Streams coefficients in and results out over valid/ready handshakes; sits between the coefficient source and the pointwise-multiply stage of the NTT datapath.

---
 rtl/ntt_pkg.sv | 25 ++
 rtl/ntt_bf_pipe.sv | 60 ++++++
 rtl/ntt_iter_core.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_pkg.sv
// Shared types and helpers for the iterative NTT core: FSM states,
// index bit-reversal and the butterfly pipeline depth.
package ntt_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOAD    = 2'd1,
      COMPUTE = 2'd2,
      OUT     = 2'd3
   } state_t;

   localparam int BF_LAT = 2;

   function automatic int bitrev(input int idx, input int logn);
      int r;
      r = 0;
      for (int b = 0; b < 32; b++) begin
         if (b < logn) begin
            r = r | (((idx >> b) & 1) << (logn - 1 - b));
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/ntt_bf_pipe.sv
// Two-stage radix-2 DIT modular butterfly: t = b*w mod q, then a+t and a-t mod q.
// Operands a, b, w are expected to be already reduced below q.
module ntt_bf_pipe #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         valid_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic [W-1:0] w_i,
   input  logic [W-1:0] q_i,
   output logic [W-1:0] a_o,
   output logic [W-1:0] b_o,
   output logic         valid_o
);

   logic [2*W-1:0] prod_s;
   logic [W-1:0]   t_d, a1_q, t_q, a_d, b_d;
   logic           v1_q;
   logic [W:0]     sum_s, dif_s;

   // Stage-1 twiddle product and stage-2 add/subtract; sums are < 2q so one correction suffices.
   always_comb begin
      prod_s = {{W{1'b0}}, b_i} * {{W{1'b0}}, w_i};
      t_d    = W'(prod_s % {{W{1'b0}}, q_i});
      sum_s  = {1'b0, a1_q} + {1'b0, t_q};
      dif_s  = {1'b0, a1_q} + {1'b0, q_i} - {1'b0, t_q};
      if (sum_s >= {1'b0, q_i}) begin
         a_d = W'(sum_s - {1'b0, q_i});
      end else begin
         a_d = W'(sum_s);
      end
      if (dif_s >= {1'b0, q_i}) begin
         b_d = W'(dif_s - {1'b0, q_i});
      end else begin
         b_d = W'(dif_s);
      end
   end

   // Pipeline registers for both stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a1_q    <= {W{1'b0}};
         t_q     <= {W{1'b0}};
         v1_q    <= 1'b0;
         a_o     <= {W{1'b0}};
         b_o     <= {W{1'b0}};
         valid_o <= 1'b0;
      end else begin
         a1_q    <= a_i;
         t_q     <= t_d;
         v1_q    <= valid_i;
         a_o     <= a_d;
         b_o     <= b_d;
         valid_o <= v1_q;
      end
   end

endmodule

// File: rtl/ntt_iter_core.sv
// Iterative N-point forward NTT over Z_q with streaming in/out and one reused butterfly.
// Define NTT_INTT_SCALE_EN to add output scaling by n_inv_i (one extra output latency cycle).
module ntt_iter_core #(
   parameter int N    = 8,
   parameter int W    = 8,
   parameter int LOGN = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] mod_i,
   input  logic [W-1:0] omega_i,
`ifdef NTT_INTT_SCALE_EN
   input  logic         scale_en_i,
   input  logic [W-1:0] n_inv_i,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_last,
   output logic         busy
);
   import ntt_pkg::*;

   localparam logic [LOGN:0] HALF_N   = (LOGN+1)'(N / 2);
   localparam logic [LOGN:0] LAST_CYC = HALF_N + (LOGN+1)'(BF_LAT - 1);

   function automatic logic [W-1:0] mulmod(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [W-1:0] q);
      logic [2*W-1:0] p;
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return W'(p % {{W{1'b0}}, q});
   endfunction

   state_t          state_q;
   logic [W-1:0]    q_q, om_q, out_data_q;
   logic            in_ready_q, out_valid_q, out_last_q, busy_q, tw_run_q;
   logic [LOGN-1:0] in_cnt_q, tw_cnt_q, stage_q, k_q;
   logic [LOGN:0]   cyc_q;
   logic [LOGN-1:0] ad1_top_q, ad1_bot_q, wb_top_q, wb_bot_q;
   logic [W-1:0]    mem [N];
   logic [W-1:0]    tw  [N];
`ifdef NTT_INTT_SCALE_EN
   logic            sc_q;
   logic [W-1:0]    ninv_q;
`endif

   logic            accept_s, issue_s, bf_valid_s;
   logic [W-1:0]    ld_q_s, ld_data_s, rd_a_s, rd_b_s, rd_w_s, bf_a_s, bf_b_s, raw_s, res_s;
   logic [LOGN-1:0] ld_addr_s, half_s, bf_i_s, j_s, top_s, bot_s, twi_s, out_idx_s;

   // Input acceptance and butterfly addressing for the current COMPUTE slot.
   always_comb begin
      accept_s  = in_valid && in_ready_q;
      ld_q_s    = (state_q == IDLE) ? mod_i : q_q;
      ld_data_s = in_data % ld_q_s;
      ld_addr_s = LOGN'(bitrev(int'(in_cnt_q), LOGN));
      half_s    = LOGN'(1) << stage_q;
      bf_i_s    = cyc_q[LOGN-1:0];
      j_s       = bf_i_s & (half_s - LOGN'(1));
      top_s     = ((bf_i_s >> stage_q) << (stage_q + LOGN'(1))) | j_s;
      bot_s     = top_s | half_s;
      twi_s     = j_s << (LOGN'(LOGN - 1) - stage_q);
      issue_s   = (state_q == COMPUTE) && (cyc_q < HALF_N);
      rd_a_s    = mem[top_s];
      rd_b_s    = mem[bot_s];
      rd_w_s    = tw[twi_s];
   end

   ntt_bf_pipe #(.W(W)) u_bf (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (issue_s),
      .a_i     (rd_a_s),
      .b_i     (rd_b_s),
      .w_i     (rd_w_s),
      .q_i     (q_q),
      .a_o     (bf_a_s),
      .b_o     (bf_b_s),
      .valid_o (bf_valid_s)
   );

   // Next output word; forwards the final write-back that lands on the COMPUTE->OUT edge.
   always_comb begin
      if ((state_q == OUT) && out_valid_q) begin
         out_idx_s = k_q + LOGN'(1);
      end else begin
         out_idx_s = {LOGN{1'b0}};
      end
      if (bf_valid_s && (wb_top_q == out_idx_s)) begin
         raw_s = bf_a_s;
      end else if (bf_valid_s && (wb_bot_q == out_idx_s)) begin
         raw_s = bf_b_s;
      end else begin
         raw_s = mem[out_idx_s];
      end
`ifdef NTT_INTT_SCALE_EN
      if (sc_q) begin
         res_s = mulmod(raw_s, ninv_q, q_q);
      end else begin
         res_s = raw_s;
      end
`else
      res_s = raw_s;
`endif
   end

   // Coefficient RAM (input stream or butterfly write-back) and twiddle table build.
   always_ff @(posedge clk) begin
      if (accept_s) begin
         mem[ld_addr_s] <= ld_data_s;
      end else if (bf_valid_s) begin
         mem[wb_top_q] <= bf_a_s;
         mem[wb_bot_q] <= bf_b_s;
      end
      if (tw_run_q) begin
         tw[tw_cnt_q] <= (tw_cnt_q == {LOGN{1'b0}}) ? W'(1) :
                         mulmod(tw[tw_cnt_q - LOGN'(1)], om_q, q_q);
      end
   end

   // Butterfly addresses travel alongside the two pipeline stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ad1_top_q <= {LOGN{1'b0}};
         ad1_bot_q <= {LOGN{1'b0}};
         wb_top_q  <= {LOGN{1'b0}};
         wb_bot_q  <= {LOGN{1'b0}};
      end else begin
         ad1_top_q <= top_s;
         ad1_bot_q <= bot_s;
         wb_top_q  <= ad1_top_q;
         wb_bot_q  <= ad1_bot_q;
      end
   end

   // Frame FSM with registered handshake outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         q_q         <= {W{1'b0}};
         om_q        <= {W{1'b0}};
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= {W{1'b0}};
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         tw_run_q    <= 1'b0;
         tw_cnt_q    <= {LOGN{1'b0}};
         in_cnt_q    <= {LOGN{1'b0}};
         stage_q     <= {LOGN{1'b0}};
         cyc_q       <= {(LOGN+1){1'b0}};
         k_q         <= {LOGN{1'b0}};
`ifdef NTT_INTT_SCALE_EN
         sc_q        <= 1'b0;
         ninv_q      <= {W{1'b0}};
`endif
      end else begin
         if (tw_run_q) begin
            tw_cnt_q <= tw_cnt_q + LOGN'(1);
            if (tw_cnt_q == LOGN'(N / 2 - 1)) begin
               tw_run_q <= 1'b0;
            end
         end
         case (state_q)
            IDLE: begin
               in_ready_q <= 1'b1;
               if (accept_s) begin
                  q_q      <= mod_i;
                  om_q     <= omega_i;
`ifdef NTT_INTT_SCALE_EN
                  sc_q     <= scale_en_i;
                  ninv_q   <= n_inv_i;
`endif
                  tw_run_q <= 1'b1;
                  tw_cnt_q <= {LOGN{1'b0}};
                  in_cnt_q <= LOGN'(1);
                  busy_q   <= 1'b1;
                  state_q  <= LOAD;
               end
            end
            LOAD: begin
               if (accept_s) begin
                  in_cnt_q <= in_cnt_q + LOGN'(1);
                  if (in_cnt_q == LOGN'(N - 1)) begin
                     in_ready_q <= 1'b0;
                     stage_q    <= {LOGN{1'b0}};
                     cyc_q      <= {(LOGN+1){1'b0}};
                     state_q    <= COMPUTE;
                  end
               end
            end
            COMPUTE: begin
               if (cyc_q == LAST_CYC) begin
                  cyc_q <= {(LOGN+1){1'b0}};
                  if (stage_q == LOGN'(LOGN - 1)) begin
                     k_q     <= {LOGN{1'b0}};
                     state_q <= OUT;
`ifndef NTT_INTT_SCALE_EN
                     out_valid_q <= 1'b1;
                     out_data_q  <= res_s;
                     out_last_q  <= (out_idx_s == LOGN'(N - 1));
`endif
                  end else begin
                     stage_q <= stage_q + LOGN'(1);
                  end
               end else begin
                  cyc_q <= cyc_q + (LOGN+1)'(1);
               end
            end
            OUT: begin
               if (!out_valid_q) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= res_s;
                  out_last_q  <= (out_idx_s == LOGN'(N - 1));
               end else if (out_ready) begin
                  if (k_q == LOGN'(N - 1)) begin
                     out_valid_q <= 1'b0;
                     out_data_q  <= {W{1'b0}};
                     out_last_q  <= 1'b0;
                     k_q         <= {LOGN{1'b0}};
                     busy_q      <= 1'b0;
                     in_ready_q  <= 1'b1;
                     state_q     <= IDLE;
                  end else begin
                     k_q        <= k_q + LOGN'(1);
                     out_data_q <= res_s;
                     out_last_q <= (out_idx_s == LOGN'(N - 1));
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;

endmodule
